// File: rtl/sap_pkg.sv
// Shared definitions for the SAP controller: opcodes, T-states and control-word bit positions.
package sap_pkg;

  localparam int STEPS = 5;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_ADI = 8'h02;
  localparam logic [7:0] OP_SUI = 8'h03;
  localparam logic [7:0] OP_LDA = 8'h04;
  localparam logic [7:0] OP_OUT = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JC  = 8'h07;
  localparam logic [7:0] OP_JZ  = 8'h08;
  localparam logic [7:0] OP_STA = 8'h09;
  localparam logic [7:0] OP_HLT = 8'hFF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam int CW_W       = 15;
  localparam int CW_MAR_IN  = 0;
  localparam int CW_RAM_IN  = 1;
  localparam int CW_RAM_OUT = 2;
  localparam int CW_IR_IN   = 3;
  localparam int CW_IR_OUT  = 4;
  localparam int CW_A_IN    = 5;
  localparam int CW_A_OUT   = 6;
  localparam int CW_ALU_OUT = 7;
  localparam int CW_ALU_SUB = 8;
  localparam int CW_B_IN    = 9;
  localparam int CW_OUT_IN  = 10;
  localparam int CW_PC_INC  = 11;
  localparam int CW_PC_OUT  = 12;
  localparam int CW_PC_JUMP = 13;
  // Halt request from the decoder; externally this position carries o_halt.
  localparam int CW_HALT    = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_controller_if.sv
// Bundle of IR/flag inputs and control strobes between the SAP controller and its datapath.
interface sap_controller_if;
  logic        i_debug;
  logic [15:0] i_instruction;
  logic        i_flag_overflow;
  logic        i_flag_zero;
  logic        o_halt;
  logic        o_memory_address_in;
  logic        o_ram_in;
  logic        o_ram_out;
  logic        o_instruction_in;
  logic        o_instruction_out;
  logic        o_register_a_in;
  logic        o_register_a_out;
  logic        o_alu_out;
  logic        o_alu_subtract;
  logic        o_register_b_in;
  logic        o_register_output_in;
  logic        o_program_counter_increment;
  logic        o_program_counter_out;
  logic        o_program_counter_jump;

  modport slave (
    input  i_debug, i_instruction, i_flag_overflow, i_flag_zero,
    output o_halt, o_memory_address_in, o_ram_in, o_ram_out, o_instruction_in,
           o_instruction_out, o_register_a_in, o_register_a_out, o_alu_out,
           o_alu_subtract, o_register_b_in, o_register_output_in,
           o_program_counter_increment, o_program_counter_out, o_program_counter_jump
  );

  modport master (
    output i_debug, i_instruction, i_flag_overflow, i_flag_zero,
    input  o_halt, o_memory_address_in, o_ram_in, o_ram_out, o_instruction_in,
           o_instruction_out, o_register_a_in, o_register_a_out, o_alu_out,
           o_alu_subtract, o_register_b_in, o_register_output_in,
           o_program_counter_increment, o_program_counter_out, o_program_counter_jump
  );
endinterface

// File: rtl/sap_microcode_decode.sv
// Combinational microcode ROM: (step, opcode, latched flags) -> control word.
module sap_microcode_decode
  import sap_pkg::*;
(
  input  t_state_e   step_i,
  input  logic [7:0] opcode_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    unique case (step_i)
      T0: begin
        cw_o[CW_PC_OUT] = 1'b1;
        cw_o[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw_o[CW_RAM_OUT] = 1'b1;
        cw_o[CW_IR_IN]   = 1'b1;
        cw_o[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDI: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_A_IN]   = 1'b1;
          end
          OP_ADI, OP_SUI: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_B_IN]   = 1'b1;
          end
          OP_LDA, OP_STA: begin
            cw_o[CW_IR_OUT] = 1'b1;
            cw_o[CW_MAR_IN] = 1'b1;
          end
          OP_OUT: begin
            cw_o[CW_A_OUT]  = 1'b1;
            cw_o[CW_OUT_IN] = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IR_OUT]  = 1'b1;
            cw_o[CW_PC_JUMP] = 1'b1;
          end
          OP_JC: begin
            cw_o[CW_IR_OUT]  = flag_c_i;
            cw_o[CW_PC_JUMP] = flag_c_i;
          end
          OP_JZ: begin
            cw_o[CW_IR_OUT]  = flag_z_i;
            cw_o[CW_PC_JUMP] = flag_z_i;
          end
          OP_HLT: cw_o[CW_HALT] = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_ADI: begin
            cw_o[CW_ALU_OUT] = 1'b1;
            cw_o[CW_A_IN]    = 1'b1;
          end
          OP_SUI: begin
            cw_o[CW_ALU_OUT] = 1'b1;
            cw_o[CW_ALU_SUB] = 1'b1;
            cw_o[CW_A_IN]    = 1'b1;
          end
          OP_LDA: begin
            cw_o[CW_RAM_OUT] = 1'b1;
            cw_o[CW_A_IN]    = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_A_OUT] = 1'b1;
            cw_o[CW_RAM_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_controller.sv
// SAP microcode sequencer: T-state counter, ALU flag latches and sticky halt.
// Optional simulation trace enabled by defining SAP_CONTROLLER_TRACE_EN.
module sap_controller
  import sap_pkg::*;
(
  input  logic           i_clock,
  input  logic           i_reset,
  sap_controller_if.slave bus
);

  t_state_e   step_q, step_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       halted_q, halted_d;
  ctrl_word_t cw;
  ctrl_word_t strobe;
  logic       enable;

  sap_microcode_decode u_decode (
    .step_i   (step_q),
    .opcode_i (bus.i_instruction[15:8]),
    .flag_c_i (flag_c_q),
    .flag_z_i (flag_z_q),
    .cw_o     (cw)
  );

  // Reset level gates outputs combinationally so nothing leaks while it is held.
  assign enable = i_reset & ~halted_q;
  assign strobe = cw & {CW_W{enable}};

  always_comb begin
    step_d   = step_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    halted_d = halted_q | strobe[CW_HALT];
    if (!halted_q) begin
      step_d = (step_q == T4) ? T0 : t_state_e'(step_q + 3'd1);
    end
    if (strobe[CW_ALU_OUT]) begin
      flag_c_d = bus.i_flag_overflow;
      flag_z_d = bus.i_flag_zero;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      step_q   <= T0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      halted_q <= halted_d;
    end
  end

  assign bus.o_halt                      = halted_q & i_reset;
  assign bus.o_memory_address_in         = strobe[CW_MAR_IN];
  assign bus.o_ram_in                    = strobe[CW_RAM_IN];
  assign bus.o_ram_out                   = strobe[CW_RAM_OUT];
  assign bus.o_instruction_in            = strobe[CW_IR_IN];
  assign bus.o_instruction_out           = strobe[CW_IR_OUT];
  assign bus.o_register_a_in             = strobe[CW_A_IN];
  assign bus.o_register_a_out            = strobe[CW_A_OUT];
  assign bus.o_alu_out                   = strobe[CW_ALU_OUT];
  assign bus.o_alu_subtract              = strobe[CW_ALU_SUB];
  assign bus.o_register_b_in             = strobe[CW_B_IN];
  assign bus.o_register_output_in        = strobe[CW_OUT_IN];
  assign bus.o_program_counter_increment = strobe[CW_PC_INC];
  assign bus.o_program_counter_out       = strobe[CW_PC_OUT];
  assign bus.o_program_counter_jump      = strobe[CW_PC_JUMP];

`ifdef SAP_CONTROLLER_TRACE_EN
  always @(posedge i_clock) begin
    if (bus.i_debug) begin
      $display("sap trace: step=T%0d op=%02h c=%0b z=%0b halt=%0b cw=%04h",
               step_q, bus.i_instruction[15:8], flag_c_q, flag_z_q, halted_q, strobe);
    end
  end
`endif

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: fetch/execute strobes, flag-conditional jumps, halt and reset.
module tb_sap_controller;
  import sap_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sap_controller_if bus ();

  sap_controller dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam ctrl_word_t NONE   = '0;
  localparam ctrl_word_t FETCH0 = ctrl_word_t'((1 << CW_PC_OUT) | (1 << CW_MAR_IN));
  localparam ctrl_word_t FETCH1 = ctrl_word_t'((1 << CW_RAM_OUT) | (1 << CW_IR_IN) | (1 << CW_PC_INC));
  localparam ctrl_word_t LDI_T2 = ctrl_word_t'((1 << CW_IR_OUT) | (1 << CW_A_IN));
  localparam ctrl_word_t ADI_T2 = ctrl_word_t'((1 << CW_IR_OUT) | (1 << CW_B_IN));
  localparam ctrl_word_t ADI_T3 = ctrl_word_t'((1 << CW_ALU_OUT) | (1 << CW_A_IN));
  localparam ctrl_word_t SUI_T3 = ctrl_word_t'((1 << CW_ALU_OUT) | (1 << CW_ALU_SUB) | (1 << CW_A_IN));
  localparam ctrl_word_t MAR_T2 = ctrl_word_t'((1 << CW_IR_OUT) | (1 << CW_MAR_IN));
  localparam ctrl_word_t LDA_T3 = ctrl_word_t'((1 << CW_RAM_OUT) | (1 << CW_A_IN));
  localparam ctrl_word_t STA_T3 = ctrl_word_t'((1 << CW_A_OUT) | (1 << CW_RAM_IN));
  localparam ctrl_word_t OUT_T2 = ctrl_word_t'((1 << CW_A_OUT) | (1 << CW_OUT_IN));
  localparam ctrl_word_t JMP_T2 = ctrl_word_t'((1 << CW_IR_OUT) | (1 << CW_PC_JUMP));
  localparam ctrl_word_t HALTED = ctrl_word_t'(1 << CW_HALT);

  function automatic ctrl_word_t observed();
    ctrl_word_t w;
    w = '0;
    w[CW_MAR_IN]  = bus.o_memory_address_in;
    w[CW_RAM_IN]  = bus.o_ram_in;
    w[CW_RAM_OUT] = bus.o_ram_out;
    w[CW_IR_IN]   = bus.o_instruction_in;
    w[CW_IR_OUT]  = bus.o_instruction_out;
    w[CW_A_IN]    = bus.o_register_a_in;
    w[CW_A_OUT]   = bus.o_register_a_out;
    w[CW_ALU_OUT] = bus.o_alu_out;
    w[CW_ALU_SUB] = bus.o_alu_subtract;
    w[CW_B_IN]    = bus.o_register_b_in;
    w[CW_OUT_IN]  = bus.o_register_output_in;
    w[CW_PC_INC]  = bus.o_program_counter_increment;
    w[CW_PC_OUT]  = bus.o_program_counter_out;
    w[CW_PC_JUMP] = bus.o_program_counter_jump;
    w[CW_HALT]    = bus.o_halt;
    return w;
  endfunction

  task automatic chk(input string tag, input ctrl_word_t exp);
    ctrl_word_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
    $display("check %-14s observed=%04h expected=%04h", tag, obs, exp);
  endtask

  // Move to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered at a T0 sample point; leaves at the following T0 sample point.
  task automatic run_instr(input string name, input logic [7:0] op,
                           input ctrl_word_t e2, input ctrl_word_t e3, input ctrl_word_t e4);
    bus.i_instruction = {op, 8'h2A};
    chk({name, "_T0"}, FETCH0); tick();
    chk({name, "_T1"}, FETCH1); tick();
    chk({name, "_T2"}, e2);     tick();
    chk({name, "_T3"}, e3);     tick();
    chk({name, "_T4"}, e4);     tick();
  endtask

  initial begin
    bus.i_debug         = 1'b0;
    bus.i_instruction   = 16'h0000;
    bus.i_flag_overflow = 1'b0;
    bus.i_flag_zero     = 1'b0;

    // Reset held while the clock runs
    #1 rst_n = 1'b0;
    #1 chk("rst_held0", NONE);
    repeat (3) tick();
    chk("rst_held3", NONE);
    rst_n = 1'b1;
    #1;

    run_instr("ldi", OP_LDI, LDI_T2, NONE, NONE);

    // 127+1 overflows: carry latched on the ADI T3 edge
    bus.i_flag_overflow = 1'b1;
    bus.i_flag_zero     = 1'b0;
    run_instr("adi_c1", OP_ADI, ADI_T2, ADI_T3, NONE);
    bus.i_flag_overflow = 1'b0;
    run_instr("jc_taken", OP_JC, JMP_T2, NONE, NONE);
    run_instr("jz_nottaken", OP_JZ, NONE, NONE, NONE);

    run_instr("adi_c0", OP_ADI, ADI_T2, ADI_T3, NONE);
    run_instr("jc_nottaken", OP_JC, NONE, NONE, NONE);

    bus.i_flag_zero = 1'b1;
    run_instr("sui_z1", OP_SUI, ADI_T2, SUI_T3, NONE);
    bus.i_flag_zero = 1'b0;
    run_instr("jz_taken", OP_JZ, JMP_T2, NONE, NONE);
    run_instr("jc_c0", OP_JC, NONE, NONE, NONE);

    run_instr("sta", OP_STA, MAR_T2, STA_T3, NONE);
    run_instr("lda", OP_LDA, MAR_T2, LDA_T3, NONE);
    run_instr("out", OP_OUT, OUT_T2, NONE, NONE);
    run_instr("jmp", OP_JMP, JMP_T2, NONE, NONE);
    run_instr("nop", OP_NOP, NONE, NONE, NONE);
    run_instr("op5a", 8'h5A, NONE, NONE, NONE);

    // Reset mid-instruction at ADI T3
    bus.i_instruction = {OP_ADI, 8'h01};
    tick(); tick(); tick();
    chk("pre_abort_T3", ADI_T3);
    rst_n = 1'b0;
    #1 chk("abort_rst", NONE);
    tick();
    chk("abort_rst_clk", NONE);
    rst_n = 1'b1;
    #1 chk("abort_T0", FETCH0);

    // Halt: sticky, no strobes, survives clocks until reset
    bus.i_instruction = {OP_HLT, 8'h00};
    chk("hlt_T0", FETCH0); tick();
    chk("hlt_T1", FETCH1); tick();
    chk("hlt_T2", NONE);   tick();
    for (int i = 0; i < 10; i++) begin
      chk("halted", HALTED);
      tick();
    end
    bus.i_instruction = {OP_LDI, 8'h00};
    chk("halted_ldi", HALTED);
    rst_n = 1'b0;
    #1 chk("hlt_rst", NONE);
    rst_n = 1'b1;
    #1 chk("hlt_rel_T0", FETCH0);
    tick();
    chk("hlt_rel_T1", FETCH1);
    tick();
    chk("hlt_rel_T2", LDI_T2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Microcode sequencer for the 8-bit SAP-style CPU; the other datapath blocks are the PC, MAR, 16-bit-wide RAM, IR, registers A/B, ALU and output register.
- Steps through fetch and execute T-states and decodes the IR opcode (i_instruction[15:8]) into one-hot control strobes on the shared bus.
- Latches the ALU carry/overflow and zero flags for conditional jumps, and implements halt.

Parameters:
- STEPS, 5, T-states per instruction (T0..T4); counter wraps T4->T0.

Ports:
- i_clock  in  1  system clock, rising-edge.
- i_reset  in  1  one clock; reset is asynchronous and active-low.
- i_debug  in  1  enables trace output (see Optional Feature); otherwise ignored.
- i_instruction  in  16  IR contents; [15:8] opcode, [7:0] immediate/address (not used internally).
- i_flag_overflow  in  1  ALU carry/overflow, combinational.
- i_flag_zero  in  1  ALU zero, combinational.
- o_halt  out  1  high once HLT has executed.
- o_memory_address_in, o_ram_in, o_ram_out, o_instruction_in, o_instruction_out, o_register_a_in, o_register_a_out, o_alu_out, o_alu_subtract, o_register_b_in, o_register_output_in, o_program_counter_increment, o_program_counter_out, o_program_counter_jump  out  1 each  control strobes, active-high.

Behaviour:
- State: step counter T0..T4, flag_c, flag_z, halted.
- Reset (i_reset=0): immediately step=T0, flags=0, halted=0. All outputs forced 0 for as long as reset is held.
- Rising edge, not halted: step advances by 1, wrapping T4->T0. Halted: step frozen.
- Strobes are combinational from step, opcode and latched flags. Strobes not listed for a step are 0.
- Fetch, all opcodes:
  - T0: program_counter_out, memory_address_in.
  - T1: ram_out, instruction_in, program_counter_increment.
- Execute (opcode at T2..T4; unlisted steps idle):
  - 0x00 NOP: none.
  - 0x01 LDI: T2 instruction_out, register_a_in.
  - 0x02 ADI: T2 instruction_out, register_b_in; T3 alu_out, register_a_in.
  - 0x03 SUI: as ADI, plus alu_subtract at T3.
  - 0x04 LDA: T2 instruction_out, memory_address_in; T3 ram_out, register_a_in.
  - 0x09 STA: T2 instruction_out, memory_address_in; T3 register_a_out, ram_in.
  - 0x05 OUT: T2 register_a_out, register_output_in.
  - 0x06 JMP: T2 instruction_out, program_counter_jump.
  - 0x07 JC: JMP strobes only if flag_c=1.
  - 0x08 JZ: JMP strobes only if flag_z=1.
  - 0xFF HLT: at T2, halted is set on the edge and o_halt=halted.
  - Any other opcode: NOP.
- Flags: on a rising edge where o_alu_out=1, flag_c<=i_flag_overflow and flag_z<=i_flag_zero. Otherwise flags hold, so JC/JZ test the most recent ADI/SUI result.
- At most one bus driver (*_out) asserted in any step.
- Halt: sticky until reset; all strobes 0 while halted.
- Reset mid-instruction aborts it with no partial strobes and restarts at T0.

Optional Feature:
- SAP_CONTROLLER_TRACE_EN defined: simulation-only $display each rising edge when i_debug=1, printing step, opcode, flags and the 15-bit control word. Not synthesized.
- Undefined: no trace code; i_debug unconnected internally.

Decomposition:
- Shared package sap_pkg:
  - opcode localparams (OP_NOP..OP_HLT);
  - T-state enum;
  - control-word bit indices, for reuse by the bench.
- One sub-module, sap_microcode_decode: pure combinational (step, opcode, flag_c, flag_z) -> control word.
- The top holds the counter, flags and halt.

Test Plan:
- Reset held low, clock toggling -> all outputs 0, no step advance. Release -> T0 shows program_counter_out=1, memory_address_in=1.
- Opcode 0x01 over T0..T4 -> T1 ram_out+instruction_in+program_counter_increment; T2 instruction_out+register_a_in; T3/T4 all 0; next T0 fetch.
- Opcode 0x02 with i_flag_overflow=1 at T3 (127+1) -> T3 alu_out+register_a_in, flag_c=1. Next instruction 0x07 -> T2 instruction_out+program_counter_jump.
- Opcode 0x07 after ADI with i_flag_overflow=0 -> T2 no strobes. Opcode 0x08 after SUI with i_flag_zero=1 -> jump strobes asserted.
- Opcode 0xFF -> o_halt=1 after the T2 edge, step frozen, all strobes 0 for 10 cycles; async reset -> o_halt=0, step=T0.
- Opcode 0x09 -> T2 instruction_out+memory_address_in, T3 register_a_out+ram_in. Opcode 0x5A -> behaves as NOP.
